// File: rtl/skel_pkg.sv
// Shared definitions for the image stream loader: FSM states and default timing.
package skel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_PACE       = 2;
  localparam int DEFAULT_RUN_CYCLES = 640;
  localparam int FRAME_COUNT_W      = 16;

endpackage

// File: rtl/pace_counter.sv
// Modulo-PACE tick generator: tick is high on the last clock of each PACE window.
module pace_counter #(
  parameter int PACE = 2,
  parameter int W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [W-1:0] count_reg;

  assign tick = enable && (count_reg == W'(PACE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/image_stream_loader.sv
// Frame buffer loaded by a host, streamed pixel by pixel to a downstream engine,
// followed by a fixed processing interval and a completion pulse.
module image_stream_loader
  import skel_pkg::*;
#(
  parameter int N          = 8,
  parameter int pixelWidth = 8,
  parameter int bitSize    = $clog2(N * N),
  parameter int PACE       = DEFAULT_PACE,
  parameter int RUN_CYCLES = DEFAULT_RUN_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_we,
  input  logic [bitSize-1:0]       host_addr,
  input  logic [pixelWidth-1:0]    host_data,
  input  logic                     start,
  input  logic                     repeat_mode,
  input  logic                     abort,
  output logic                     we,
  output logic [pixelWidth-1:0]    data_out,
  output logic                     busy,
  output logic                     done,
  output logic [FRAME_COUNT_W-1:0] frame_count
);

  localparam int PIXELS = N * N;
  localparam int RUN_W  = 16;

  state_t                   state_reg, state_next;
  logic [bitSize-1:0]       pix_reg;
  logic [RUN_W-1:0]         run_reg;
  logic [pixelWidth-1:0]    data_reg;
  logic [FRAME_COUNT_W-1:0] frame_count_reg;
  logic [pixelWidth-1:0]    mem [PIXELS];

  logic                     tick;
  logic                     load;
  logic                     pix_inc;
  logic                     frame_done;
  logic                     wr_en;
  logic [bitSize-1:0]       rd_addr;
  logic [pixelWidth-1:0]    rd_word;

  pace_counter #(
    .PACE (PACE),
    .W    (8)
  ) u_pace (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_reg != STREAM),
    .enable (state_reg == STREAM),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // load fetches the pixel that becomes visible on data_out next clock
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    pix_inc    = 1'b0;
    frame_done = 1'b0;
    rd_addr    = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
          load       = 1'b1;
        end
      end
      STREAM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick) begin
          if (pix_reg == bitSize'(PIXELS - 1)) begin
            state_next = RUN;
          end else begin
            load    = 1'b1;
            pix_inc = 1'b1;
            rd_addr = pix_reg + 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (run_reg == RUN_W'(RUN_CYCLES - 1)) begin
          state_next = DONE;
          frame_done = 1'b1;
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (repeat_mode) begin
          state_next = STREAM;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_en = host_we && (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[host_addr] <= host_data;
  end

  // A host write in the launch cycle must already be part of the frame.
  assign rd_word = (wr_en && (host_addr == rd_addr)) ? host_data : mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg        <= '0;
      pix_reg         <= '0;
      run_reg         <= '0;
      frame_count_reg <= '0;
    end else begin
      if (load) data_reg <= rd_word;

      if (state_reg != STREAM) pix_reg <= '0;
      else if (pix_inc)        pix_reg <= pix_reg + 1'b1;

      if (state_reg == RUN && state_next == RUN) run_reg <= run_reg + 1'b1;
      else                                       run_reg <= '0;

      if (frame_done) frame_count_reg <= frame_count_reg + 1'b1;
    end
  end

  assign we          = (state_reg == STREAM);
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign data_out    = data_reg;
  assign frame_count = frame_count_reg;

endmodule
